// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
// Contents: address/data width constants, arbiter state enum, port id type.
package dmem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef logic port_id_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: two request ports with
// grant and registered read response.
//   master : requester side (drives req/lock/we/addr/wdata)
//   slave  : arbiter side  (drives gnt/rvalid/rdata)
interface data_mem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);
  logic              req0,    req1;
  logic              lock0,   lock1;
  logic              we0,     we1;
  logic [ADDR_W-1:0] addr0,   addr1;
  logic [DATA_W-1:0] wdata0,  wdata1;
  logic              gnt0,    gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0,  rdata1;

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_i        : request vector
//   last_grant_i : port granted most recently (loses a conflict)
//   gnt_o        : one-hot grant (zero when nothing requests)
//   winner_id_o  : index of the granted port (0 when no grant)
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_grant_i,
  output logic [1:0] gnt_o,
  output port_id_t   winner_id_o
);
  always_comb begin
    gnt_o       = 2'b00;
    winner_id_o = 1'b0;
    case (req_i)
      2'b01: begin gnt_o = 2'b01; winner_id_o = 1'b0; end
      2'b10: begin gnt_o = 2'b10; winner_id_o = 1'b1; end
      2'b11: begin
        winner_id_o = ~last_grant_i;
        gnt_o       = last_grant_i ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter for the single-ported dataMemory with
// lockable bursts (capped at MAX_LOCK grants) and registered read return.
//   clk, resetN : clock, asynchronous active-low reset
//   bus         : requester ports (slave modport)
//   memWE/memAddr/memDataIn : to dataMemory
//   memDataOut  : combinational read data from dataMemory
module data_mem_arbiter #(
  parameter int ADDR_W   = dmem_pkg::ADDR_W,
  parameter int DATA_W   = dmem_pkg::DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  data_mem_arbiter_if.slave       bus,
  output logic                    memWE,
  output logic [ADDR_W-1:0]       memAddr,
  output logic [DATA_W-1:0]       memDataIn,
  input  logic [DATA_W-1:0]       memDataOut
);
  import dmem_pkg::*;

  localparam int CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);

  arb_state_t        state_q,     state_d;
  port_id_t          ownerId_q,   ownerId_d;
  logic [CNT_W-1:0]  lockCnt_q,   lockCnt_d;
  port_id_t          lastGrant_q, lastGrant_d;
  logic [1:0]        rvalid_q,    rvalid_d;
  logic [DATA_W-1:0] rdata0_q,    rdata0_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;

  logic [1:0]       req, lock, we, rr_gnt, gnt;
  port_id_t         rr_win, win;
  logic             owner_active, granted;
  logic [CNT_W-1:0] cnt_inc;

  assign req  = {bus.req1,  bus.req0};
  assign lock = {bus.lock1, bus.lock0};
  assign we   = {bus.we1,   bus.we0};

  rr_pick2 u_pick (
    .req_i        (req),
    .last_grant_i (lastGrant_q),
    .gnt_o        (rr_gnt),
    .winner_id_o  (rr_win)
  );

  // A locked owner that keeps requesting bypasses round-robin; if it drops
  // its request the cycle falls back to plain round-robin.
  assign owner_active = (state_q == ARB_LOCKED) && req[ownerId_q];
  assign cnt_inc      = lockCnt_q + 1'b1;

  always_comb begin
    win = owner_active ? ownerId_q : rr_win;
    gnt = owner_active ? (ownerId_q ? 2'b10 : 2'b01) : rr_gnt;
    if (!resetN) gnt = 2'b00;
    granted = |gnt;

    memWE     = granted & we[win];
    memAddr   = '0;
    memDataIn = '0;
    if (granted) begin
      memAddr   = win ? bus.addr1  : bus.addr0;
      memDataIn = win ? bus.wdata1 : bus.wdata0;
    end

    state_d     = ARB_IDLE;
    ownerId_d   = ownerId_q;
    lockCnt_d   = '0;
    lastGrant_d = granted ? win : lastGrant_q;
    if (owner_active) begin
      if (lock[ownerId_q] && (cnt_inc < CNT_W'(MAX_LOCK))) begin
        state_d   = ARB_LOCKED;
        lockCnt_d = cnt_inc;
      end
    end else if (granted && lock[win] && (MAX_LOCK > 1)) begin
      state_d   = ARB_LOCKED;
      ownerId_d = win;
      lockCnt_d = CNT_W'(1);
    end

    rvalid_d[0] = granted && (win == 1'b0) && !we[0];
    rvalid_d[1] = granted && (win == 1'b1) && !we[1];
    rdata0_d    = rvalid_d[0] ? memDataOut : rdata0_q;
    rdata1_d    = rvalid_d[1] ? memDataOut : rdata1_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ARB_IDLE;
      ownerId_q   <= 1'b0;
      lockCnt_q   <= '0;
      lastGrant_q <= 1'b1;
      rvalid_q    <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      ownerId_q   <= ownerId_d;
      lockCnt_q   <= lockCnt_d;
      lastGrant_q <= lastGrant_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        memWE;
  logic [9:0]  memAddr;
  logic [31:0] memDataIn, memDataOut;
  logic [31:0] dmem [1024];

  data_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  data_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .bus        (bus),
    .memWE      (memWE),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut)
  );

  always #5 clk = ~clk;

  // dataMemory stand-in: combinational read, posedge write
  always @(posedge clk) if (memWE) dmem[memAddr] <= memDataIn;
  assign memDataOut = dmem[memAddr];

  // Stimulus
  logic        ireq [2], ilock [2], iwe [2];
  logic [9:0]  iaddr [2];
  logic [31:0] iwd [2];

  // Reference model
  int          owner, burst, last;
  logic [31:0] rmem [1024];
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  int          g;
  int          gnt1_run;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0 = ireq[0];  bus.lock0 = ilock[0]; bus.we0 = iwe[0];
    bus.addr0 = iaddr[0]; bus.wdata0 = iwd[0];
    bus.req1 = ireq[1];  bus.lock1 = ilock[1]; bus.we1 = iwe[1];
    bus.addr1 = iaddr[1]; bus.wdata1 = iwd[1];
  endtask

  task automatic set_port(input int p, input logic r, input logic l, input logic w,
                          input logic [9:0] a, input logic [31:0] d);
    ireq[p] = r; ilock[p] = l; iwe[p] = w; iaddr[p] = a; iwd[p] = d;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    drive();
  endtask

  task automatic model_reset();
    owner = -1; burst = 0; last = 1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, then advance.
  task automatic step();
    drive();
    @(negedge clk);
    check("rvalid0", 32'(bus.rvalid0), 32'(exp_rv[0]));
    check("rvalid1", 32'(bus.rvalid1), 32'(exp_rv[1]));
    check("rdata0", bus.rdata0, exp_rd[0]);
    check("rdata1", bus.rdata1, exp_rd[1]);
    if (owner >= 0 && ireq[owner]) begin
      g = owner;
      burst++;
      if (!(ilock[owner] && burst < MAXL)) owner = -1;
    end else begin
      owner = -1;
      if (ireq[0] && ireq[1]) g = 1 - last;
      else if (ireq[0])       g = 0;
      else if (ireq[1])       g = 1;
      else                    g = -1;
      if (g >= 0 && ilock[g] && MAXL > 1) begin owner = g; burst = 1; end
    end
    check("gnt0", 32'(bus.gnt0), 32'(g == 0));
    check("gnt1", 32'(bus.gnt1), 32'(g == 1));
    check("memWE", 32'(memWE), 32'(g >= 0 && iwe[g]));
    check("memAddr", 32'(memAddr), (g >= 0) ? 32'(iaddr[g]) : 32'd0);
    check("memDataIn", memDataIn, (g >= 0) ? iwd[g] : 32'd0);
    gnt1_run = (g == 1) ? gnt1_run + 1 : 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (g >= 0) begin
      last = g;
      if (iwe[g]) rmem[iaddr[g]] = iwd[g];
      else begin exp_rv[g] = 1'b1; exp_rd[g] = rmem[iaddr[g]]; end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously (mid-cycle), check reset values, release.
  task automatic do_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_memWE", 32'(memWE), 32'd0);
    check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("rst_rdata0", bus.rdata0, 32'd0);
    check("rst_rdata1", bus.rdata1, 32'd0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rst_hold_rvalid1", 32'(bus.rvalid1), 32'd0);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin dmem[i] = 32'd0; rmem[i] = 32'd0; end
    gnt1_run = 0;
    g = -1;
    model_reset();
    idle_inputs();
    #2;
    do_reset();

    // Single port 0 write then read back
    set_port(0, 1, 0, 1, 10'd5, 32'hDEADBEEF); step();
    set_port(0, 1, 0, 0, 10'd5, 32'd0);        step();
    set_port(0, 0, 0, 0, 10'd0, 32'd0);        step();
    check("p0_readback", bus.rdata0, 32'hDEADBEEF);

    // Both ports read continuously: alternating grants
    set_port(0, 1, 0, 1, 10'd1, 32'h1111_1111); step();
    set_port(0, 0, 0, 0, 10'd0, 32'd0);
    set_port(1, 1, 0, 1, 10'd2, 32'h2222_2222); step();
    set_port(0, 1, 0, 0, 10'd1, 32'd0);
    set_port(1, 1, 0, 0, 10'd2, 32'd0);
    for (int i = 0; i < 6; i++) step();
    idle_inputs(); step();

    // Make port 0 the last grant, then port 1 locks against port 0
    set_port(0, 1, 0, 0, 10'd3, 32'd0); step();
    set_port(1, 1, 1, 0, 10'd4, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("lock_run_len", 32'(gnt1_run), 32'(MAXL));
    step();
    check("after_cap_gnt0", 32'(last), 32'd0);
    idle_inputs(); step();

    // Owner drops req after 2 locked grants
    set_port(0, 1, 0, 0, 10'd1, 32'd0);
    set_port(1, 1, 1, 0, 10'd2, 32'd0);
    step(); step();
    set_port(1, 0, 0, 0, 10'd0, 32'd0);
    step();
    idle_inputs(); step();

    // Reset in the middle of a locked read burst
    set_port(0, 1, 0, 0, 10'd1, 32'd0);
    set_port(1, 1, 1, 0, 10'd2, 32'd0);
    step(); step();
    drive();
    @(negedge clk);
    check("pre_rst_grant", 32'(bus.gnt0 | bus.gnt1), 32'd1);
    do_reset();
    set_port(0, 1, 0, 0, 10'd1, 32'd0);
    set_port(1, 1, 0, 0, 10'd2, 32'd0);
    step();
    check("post_rst_first", 32'(last), 32'd0);
    idle_inputs(); step();

    // Write addr 7 from port 0 while port 1 reads addr 7
    set_port(0, 1, 0, 1, 10'd7, 32'h12345678);
    set_port(1, 1, 0, 0, 10'd7, 32'd0);
    do_reset();
    set_port(0, 1, 0, 1, 10'd7, 32'h12345678);
    set_port(1, 1, 0, 0, 10'd7, 32'd0);
    step();
    set_port(0, 0, 0, 0, 10'd0, 32'd0);
    step();
    idle_inputs(); step();
    check("raw_rdata1", bus.rdata1, 32'h12345678);

    // Randomized traffic on a small address window
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 10'($urandom_range(0, 7)), $urandom);
      step();
    end
    idle_inputs(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
